// File: rtl/fxp_pkg.sv
// fxp_pkg -- shared definitions for the sign-magnitude fixed-point adders.
//
// Contents:
//   FXP_OP_ADD / FXP_OP_SUB : encoding of the 'op' input (A+B / A-B).
//   fxp_sign(w, n)          : sign bit of an n-bit sign-magnitude word.
//   fxp_mag(w, n)           : magnitude field (low n-1 bits) of an n-bit word.
//
// The helpers take the word zero-extended to FXP_MAX_W bits plus the real
// width, so one function serves every word width up to FXP_MAX_W.
package fxp_pkg;

  localparam logic FXP_OP_ADD = 1'b0;
  localparam logic FXP_OP_SUB = 1'b1;

  localparam int FXP_MAX_W = 64;

  function automatic logic fxp_sign(input logic [FXP_MAX_W-1:0] w,
                                    input int unsigned n);
    logic [FXP_MAX_W-1:0] t;
    t = w >> (n - 1);
    return t[0];
  endfunction

  function automatic logic [FXP_MAX_W-1:0] fxp_mag(input logic [FXP_MAX_W-1:0] w,
                                                   input int unsigned n);
    logic [FXP_MAX_W-1:0] m;
    m = (64'd1 << (n - 1)) - 64'd1;
    return w & m;
  endfunction

endpackage

// File: rtl/fxp_mag_addsub.sv
// fxp_mag_addsub -- combinational magnitude datapath for the S1 stage.
//
// Ports:
//   mag_a, mag_b : M-bit unsigned magnitudes.
//   same_sign    : 1 -> add magnitudes, 0 -> subtract smaller from larger.
//   mag_res      : M-bit result magnitude (low M bits of the sum when adding).
//   carry        : carry out of the magnitude MSB (only when adding).
//   b_larger     : mag_b strictly greater than mag_a (picks the result sign).
module fxp_mag_addsub #(
  parameter int M = 31
) (
  input  logic [M-1:0] mag_a,
  input  logic [M-1:0] mag_b,
  input  logic         same_sign,
  output logic [M-1:0] mag_res,
  output logic         carry,
  output logic         b_larger
);

  logic [M:0] sum;

  assign sum = {1'b0, mag_a} + {1'b0, mag_b};

  always_comb begin
    mag_res  = '0;
    carry    = 1'b0;
    b_larger = (mag_b > mag_a);
    if (same_sign) begin
      {carry, mag_res} = sum;
    end else if (b_larger) begin
      mag_res = mag_b - mag_a;
    end else begin
      mag_res = mag_a - mag_b;
    end
  end

endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// fixed_point_addsub_pipe -- 2-stage sign-magnitude fixed-point add/subtract.
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset.
//   in_valid/in_ready   : operand handshake; a, b (N-bit sign-magnitude), op.
//   out_valid/out_ready : result handshake; c (N-bit sign-magnitude),
//                         ovf (magnitude overflow), zero (magnitude is zero).
//   ovf_cnt, cnt_clr    : saturating count of delivered overflowed results,
//                         synchronous clear (clear beats increment).
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Producers hold valid and data stable until the transfer; in_ready is a
// function of pipeline state and out_ready only, never of in_valid.
//
// Build option: FXP_ADDSUB_SATURATE_EN defined -> an overflowed magnitude is
// clamped to all-ones; undefined -> it wraps to the low N-1 bits of the sum.
//
// Q (fractional bits) does not change the arithmetic; it only documents the
// binary point and is range-checked at elaboration.
module fixed_point_addsub_pipe
  import fxp_pkg::*;
#(
  parameter int N  = 32,
  parameter int Q  = 15,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  c,
  output logic          ovf,
  output logic          zero,
  output logic [CW-1:0] ovf_cnt,
  input  logic          cnt_clr
);

  if (Q < 0 || Q > N - 2) begin : g_q_range_check
    $error("fixed_point_addsub_pipe: Q must lie in 0..N-2");
  end

  localparam int unsigned NU = N;

  // ---------------- operand decode ----------------
  logic [FXP_MAX_W-1:0] a_mag_w, b_mag_w;
  logic [N-2:0]         a_mag, b_mag;
  logic                 a_sign, b_eff_sign;

  always_comb begin
    a_mag_w    = fxp_mag(FXP_MAX_W'(a), NU);
    b_mag_w    = fxp_mag(FXP_MAX_W'(b), NU);
    a_mag      = a_mag_w[N-2:0];
    b_mag      = b_mag_w[N-2:0];
    a_sign     = fxp_sign(FXP_MAX_W'(a), NU);
    // Subtraction is addition of B with its sign flipped.
    b_eff_sign = fxp_sign(FXP_MAX_W'(b), NU) ^ (op == FXP_OP_SUB);
  end

  logic [N-2:0] mag_res;
  logic         mag_carry, mag_b_larger;

  fxp_mag_addsub #(.M(N - 1)) u_mag (
    .mag_a     (a_mag),
    .mag_b     (b_mag),
    .same_sign (a_sign == b_eff_sign),
    .mag_res   (mag_res),
    .carry     (mag_carry),
    .b_larger  (mag_b_larger)
  );

  // ---------------- stall control ----------------
  logic s1_valid;
  logic s2_load;
  logic accept;

  always_comb begin
    s2_load  = !out_valid || out_ready;
    in_ready = !s1_valid || s2_load;
    accept   = in_valid && in_ready;
  end

  // ---------------- stage 1 ----------------
  logic         s1_sign_a, s1_sign_b, s1_same, s1_b_larger, s1_carry;
  logic [N-2:0] s1_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_sign_a   <= 1'b0;
      s1_sign_b   <= 1'b0;
      s1_same     <= 1'b0;
      s1_b_larger <= 1'b0;
      s1_carry    <= 1'b0;
      s1_mag      <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign_a   <= a_sign;
        s1_sign_b   <= b_eff_sign;
        s1_same     <= (a_sign == b_eff_sign);
        s1_b_larger <= mag_b_larger;
        s1_carry    <= mag_carry;
        s1_mag      <= mag_res;
      end
    end
  end

  // ---------------- stage 2 result formation ----------------
  logic         res_sign, res_zero;
  logic [N-2:0] res_mag;

  always_comb begin
    // Opposite signs: the larger magnitude owns the sign. On a tie the
    // magnitude is zero and the sign is forced to 0 below anyway.
    res_sign = (!s1_same && s1_b_larger) ? s1_sign_b : s1_sign_a;
`ifdef FXP_ADDSUB_SATURATE_EN
    res_mag  = s1_carry ? '1 : s1_mag;
`else
    res_mag  = s1_mag;
`endif
    res_zero = (res_mag == '0);
    if (res_zero) begin
      res_sign = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= '0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        c    <= {res_sign, res_mag};
        ovf  <= s1_carry;
        zero <= res_zero;
      end
    end
  end

  // ---------------- overflow counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && ovf && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// tb_fixed_point_addsub_pipe -- self-checking bench for fixed_point_addsub_pipe.
// Honors FXP_ADDSUB_SATURATE_EN the same way the design does.
module tb_fixed_point_addsub_pipe;

  localparam int N  = 32;
  localparam int Q  = 15;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          op;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  c;
  logic          ovf;
  logic          zero;
  logic [CW-1:0] ovf_cnt;
  logic          cnt_clr;

  fixed_point_addsub_pipe #(.N(N), .Q(Q), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ovf       (ovf),
    .zero      (zero),
    .ovf_cnt   (ovf_cnt),
    .cnt_clr   (cnt_clr)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int delivered = 0;
  int exp_cnt = 0;
  bit prev_hold = 1'b0;
  bit saw_backpressure = 1'b0;
  logic [N+1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result computed from the sign-magnitude rules with plain
  // integer arithmetic. Returns {c, ovf, zero}.
  function automatic logic [N+1:0] model(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                                         input logic top);
    longint ma, mb, mag, lim;
    logic sa, sb, sgn, ov;
    logic [N-2:0] mag_bits;
    lim = longint'(1) << (N - 1);
    ma  = longint'(ta[N-2:0]);
    mb  = longint'(tb_v[N-2:0]);
    sa  = ta[N-1];
    sb  = tb_v[N-1] ^ top;
    ov  = 1'b0;
    if (sa == sb) begin
      mag = ma + mb;
      sgn = sa;
      if (mag >= lim) begin
        ov = 1'b1;
`ifdef FXP_ADDSUB_SATURATE_EN
        mag = lim - 1;
`else
        mag = mag - lim;
`endif
      end
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = sa;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    if (mag == 0) sgn = 1'b0;
    mag_bits = mag[N-2:0];
    return {sgn, mag_bits, ov, (mag == 0)};
  endfunction

  // ---------------- scoreboard (samples on falling edge) ----------------
  always @(negedge clk) begin
    logic [N+1:0] e;
    bit inc;
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt   = 0;
      prev_hold = 1'b0;
    end else begin
      check("ovf_cnt", 64'(ovf_cnt), 64'(exp_cnt));
      if (prev_hold) check("hold_valid", 64'(out_valid), 64'(1));
      inc = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%0h expected no result", c);
        end else begin
          e = exp_q[0];
          check("result", 64'({c, ovf, zero}), 64'(e));
          if (out_ready) begin
            void'(exp_q.pop_front());
            delivered++;
            inc = e[1];
          end
        end
      end
      if (cnt_clr) exp_cnt = 0;
      else if (inc && exp_cnt < CNT_MAX) exp_cnt++;
      if (in_valid && in_ready) exp_q.push_back(model(a, b, op));
      if (in_valid && !in_ready) saw_backpressure = 1'b1;
      prev_hold = out_valid && !out_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic top);
    bit got;
    got = 1'b0;
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [N-1:0] ec, input logic eo,
                             input logic ez);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got out_valid=0 expected 1 within 10 cycles", name);
    end else begin
      check({name, "_c"}, 64'(c), 64'(ec));
      check({name, "_ovf"}, 64'(ovf), 64'(eo));
      check({name, "_zero"}, 64'(zero), 64'(ez));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [N-1:0] vec_a [8];
  logic [N-1:0] vec_b [8];

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    logic [N-1:0] ovf_c;
    logic ovf_z;
`ifdef FXP_ADDSUB_SATURATE_EN
    ovf_c = 32'h7FFF_FFFF;
    ovf_z = 1'b0;
`else
    ovf_c = 32'h0000_0000;
    ovf_z = 1'b1;
`endif
    vec_a = '{32'h0000_C000, 32'h0000_8000, 32'h8000_0000, 32'h7FFF_FFFF,
              32'h8001_2345, 32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vec_b = '{32'h0001_2000, 32'h8001_8000, 32'h0000_0000, 32'h0000_0001,
              32'h0001_2345, 32'h4000_0000, 32'h8000_0000, 32'h8000_0001};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    a = '0; b = '0; op = 1'b0;

    // Model pinned against hand-computed values.
    check("model_add",   64'(model(32'h0000_C000, 32'h0001_2000, 1'b0)), 64'({32'h0001_E000, 2'b00}));
    check("model_mixed", 64'(model(32'h0000_8000, 32'h8001_8000, 1'b0)), 64'({32'h8001_0000, 2'b00}));
    check("model_sub",   64'(model(32'h0000_8000, 32'h8001_8000, 1'b1)), 64'({32'h0002_0000, 2'b00}));
    check("model_negz",  64'(model(32'h8000_0000, 32'h0000_0000, 1'b0)), 64'({32'h0000_0000, 2'b01}));
    check("model_ovf",   64'(model(32'h7FFF_FFFF, 32'h0000_0001, 1'b0)), 64'({ovf_c, 1'b1, ovf_z}));

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_c", 64'(c), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_zero", 64'(zero), 64'(0));
    check("rst_ovf_cnt", 64'(ovf_cnt), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Latency: presented in cycle 0, valid in cycle 2.
    send(32'h0000_C000, 32'h0001_2000, 1'b0);
    @(negedge clk);
    check("lat_early_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("lat_valid", 64'(out_valid), 64'(1));
    check("lat_c", 64'(c), 64'(32'h0001_E000));
    check("lat_ovf", 64'(ovf), 64'(0));
    check("lat_zero", 64'(zero), 64'(0));
    @(posedge clk);
    #1;

    send(32'h0000_8000, 32'h8001_8000, 1'b0);
    wait_result("mixed_add", 32'h8001_0000, 1'b0, 1'b0);
    send(32'h0000_8000, 32'h8001_8000, 1'b1);
    wait_result("mixed_sub", 32'h0002_0000, 1'b0, 1'b0);
    send(32'h0000_8000, 32'h0000_8000, 1'b1);
    wait_result("cancel", 32'h0000_0000, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0000, 1'b0);
    wait_result("neg_zero", 32'h0000_0000, 1'b0, 1'b1);

    // Overflow and counter.
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_result("ovf", ovf_c, 1'b1, ovf_z);
    check("ovf_cnt_inc", 64'(ovf_cnt), 64'(1));
    cnt_clr = 1'b1;
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_result("ovf_clr", ovf_c, 1'b1, ovf_z);
    check("ovf_cnt_clr", 64'(ovf_cnt), 64'(0));
    cnt_clr = 1'b0;
    for (int i = 0; i < CNT_MAX + 2; i++) send(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    drain();
    check("ovf_cnt_sat", 64'(ovf_cnt), 64'(CNT_MAX));

    // Six back-to-back ops with out_ready low for cycles 2..6.
    saw_backpressure = 1'b0;
    d0 = delivered;
    fork
      begin
        for (int i = 0; i < 6; i++) send(vec_a[i], vec_b[(i + 3) % 8], i[0]);
      end
      begin
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_backpressure", 64'(saw_backpressure), 64'(1));
    check("stall_delivered", 64'(delivered - d0), 64'(6));

    // Random backpressure over the directed vector table.
    fork
      begin
        for (int i = 0; i < 24; i++)
          send(vec_a[$urandom_range(0, 7)], vec_b[$urandom_range(0, 7)], 1'($urandom_range(0, 1)));
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
    check("random_drained", 64'(exp_q.size()), 64'(0));

    // Reset with both stages full and output stalled.
    out_ready = 1'b0;
    send(32'h0000_1000, 32'h0000_2000, 1'b0);
    send(32'h0000_3000, 32'h0000_4000, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_ovf_cnt", 64'(ovf_cnt), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_no_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    send(32'h0000_8000, 32'h0000_8000, 1'b0);
    wait_result("postrst", 32'h0001_0000, 1'b0, 1'b0);
    drain();
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
